// File: rtl/loader_write_buffer.sv
// Write buffer between game_loader and the SDRAM front-end: queues {addr, data}
// writes and replays them one per NES slot, and reports load completion once drained.
module loader_write_buffer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 22
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_write,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [7:0]              in_data,
    input  logic                    in_done,
    input  logic                    slot,
    output logic                    mem_write,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [7:0]              mem_data,
    output logic                    in_ready,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    done
);

    localparam int AW    = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              overflow_q, overflow_d;
    logic              done_seen_q, done_seen_d;
    logic              done_q, done_d;

    logic [ENT_W-1:0]  fifo_q [DEPTH];
    logic [ENT_W-1:0]  head;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = slot && !empty;
    // A full FIFO can still take a write when the head leaves on the same edge.
    assign push  = in_write && (!full || pop);
    assign head  = fifo_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
        overflow_d  = overflow_q | (in_write && full && !pop);
        done_seen_d = in_done;
        if (slot) begin
            if (!empty) begin
                state_d    = ISSUE;
                mem_addr_d = head[ENT_W-1:8];
                mem_data_d = head[7:0];
            end else begin
                state_d = IDLE;
            end
        end
        // Evaluated on next-state values so done rises on the edge the last issue ends.
        done_d = done_seen_d && (wr_ptr_d == rd_ptr_d) && (state_d == IDLE) && !in_write;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            overflow_q  <= 1'b0;
            done_seen_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            overflow_q  <= overflow_d;
            done_seen_q <= done_seen_d;
            done_q      <= done_d;
        end
    end

    // Entry storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= {in_addr, in_data};
        end
    end

    assign mem_write = (state_q == ISSUE);
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign in_ready  = !full;
    assign level     = wr_ptr_q - rd_ptr_q;
    assign overflow  = overflow_q;
    assign done      = done_q;

endmodule

// File: doc/loader_write_buffer.md
LOADER_WRITE_BUFFER -- requirements
Module: loader_write_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, setting the FIFO entry count; legal values are powers of two from 2 to 64.
REQ-002 The module SHALL have parameter ADDR_W, default 22, setting the SDRAM byte-address width.
REQ-003 The module SHALL use a single clock and an asynchronous, active-high reset, on ports `clk` and `reset` as follows.
REQ-004 Port `clk`: input, 1 bit, system clock shared with game_loader, the NES core and the sdram front-end.
REQ-005 Port `reset`: input, 1 bit; active-high asynchronous reset.
REQ-006 Port `in_write`: input, 1 bit; one-cycle write strobe from game_loader.
REQ-007 Port `in_addr`: input, ADDR_W bits; write address, sampled when `in_write`=1.
REQ-008 Port `in_data`: input, 8 bits; write data, sampled when `in_write`=1.
REQ-009 Port `in_done`: input, 1 bit; game_loader done level.
REQ-010 Port `slot`: input, 1 bit; one-cycle strobe once per NES tick (nes_ce==3).
REQ-011 Port `mem_write`: output, 1 bit; SDRAM write request.
REQ-012 Port `mem_addr`: output, ADDR_W bits; SDRAM write address.
REQ-013 Port `mem_data`: output, 8 bits; SDRAM write data.
REQ-014 Port `in_ready`: output, 1 bit; 1 when the FIFO is not full.
REQ-015 Port `level`: output, log2(DEPTH)+1 bits; current FIFO occupancy.
REQ-016 Port `overflow`: output, 1 bit; sticky flag indicating a write was dropped.
REQ-017 Port `done`: output, 1 bit; load complete and fully drained; drives the top-level load_done.

Function
REQ-018 The FIFO SHALL be first-in first-out, each entry holding {addr, data}, with read/write pointers of log2(DEPTH)+1 bits; full = MSBs differ and LSBs equal, empty = pointers equal.
REQ-019 Push SHALL occur when `in_write`=1 and (not full, or a pop occurs in the same cycle).
REQ-020 When `in_write`=1, the FIFO is full and no pop occurs, the entry SHALL be dropped and `overflow` SHALL set, remaining set until reset.
REQ-021 The output stage SHALL be a two-state FSM, IDLE (`mem_write`=0) and ISSUE (`mem_write`=1), that changes state only on cycles with `slot`=1.
REQ-022 On `slot` in IDLE or ISSUE with the FIFO non-empty, the head SHALL pop into `mem_addr`/`mem_data` and the next state SHALL be ISSUE.
REQ-023 On `slot` with the FIFO empty, the next state SHALL be IDLE; `mem_addr`/`mem_data` SHALL hold their last values.
REQ-024 `mem_write`, `mem_addr` and `mem_data` SHALL be registered and stable for the whole slot period, from one `slot` to the next, giving 4 clocks at nes_ce rate.
REQ-025 Latency SHALL be as follows: a write pushed into an empty FIFO with no active ISSUE appears on `mem_write` the cycle after the next `slot`; a push on the same cycle as `slot` into an empty FIFO waits for the following `slot`.
REQ-026 Each accepted input SHALL produce exactly one ISSUE period, in arrival order; back-to-back entries SHALL issue in consecutive slots with no IDLE gap.
REQ-027 `level` SHALL equal pushes minus pops, with a simultaneous push and pop leaving it unchanged; `in_ready` SHALL be the negation of full.
REQ-028 `done_seen` SHALL set on any cycle with `in_done`=1 and clear on any cycle with `in_done`=0.
REQ-029 `done` SHALL be registered and equal to 1 only when `done_seen`=1, the FIFO is empty, the FSM is in IDLE and `in_write`=0.
REQ-030 A write arriving while `done`=1 SHALL cause `done` to fall on the next clock and re-rise after that write has drained.
REQ-031 A `slot` arriving while `reset`=1 SHALL be ignored.

Reset
REQ-032 While `reset`=1, independent of `clk`, the module SHALL clear the pointers, set `level`=0, `mem_write`=0, `mem_addr`=0, `mem_data`=0, `overflow`=0, `done_seen`=0 and `done`=0, enter IDLE, and drive `in_ready`=1.
REQ-033 Reset asserted mid-ISSUE SHALL drop `mem_write` immediately and discard all buffered entries.
REQ-034 After reset deasserts, the first `slot` SHALL issue only entries pushed after the deassertion.

Verification
REQ-035 Single write: push (0x000010, 0xA5) with `slot` every 4th clock -> exactly one 4-clock `mem_write` with addr 0x000010 and data 0xA5, then IDLE.
REQ-036 Burst: 8 back-to-back pushes of data 0x00..0x07 with DEPTH=8 -> `level` reaches 8 and `in_ready`=0; 8 consecutive ISSUE slots in order 0x00..0x07; `overflow`=0.
REQ-037 Overflow: 9 pushes with no `slot` -> the 9th is dropped and `overflow`=1; after draining, exactly 8 writes are issued, and `overflow` stays 1.
REQ-038 Full plus simultaneous push/pop: with the FIFO full, push on a `slot` cycle -> the push is accepted, `level` stays 8 and `overflow`=0.
REQ-039 Done gating: `in_done` rises with 3 entries queued -> `done` stays 0 until the third ISSUE slot ends, then rises within 1 clock.
REQ-040 Reset mid-burst: assert `reset` during ISSUE with `level`=5 -> `mem_write`=0 and `level`=0 immediately; no stale writes appear after release.
